// File: rtl/digital_lock_ctrl.sv
// rtl/digital_lock_ctrl.sv - keypad door-lock controller with timed unlock, lockout and code programming
module digital_lock_ctrl #(
  parameter int                   NDIGITS        = 4,
  parameter logic [NDIGITS*4-1:0] CODE           = 16'h1010,
  parameter int                   MAX_TRIES      = 3,
  parameter int                   UNLOCK_CYCLES  = 500,
  parameter int                   LOCKOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       key_clear,
  input  logic       lock_req,
  input  logic       prog_req,
  output logic       unlock,
  output logic       alarm,
  output logic       bad_code,
  output logic       prog_done,
  output logic [3:0] fail_count,
  output logic [3:0] digit_count
);

  localparam int W    = NDIGITS * 4;
  localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX);
  localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0]    LAST_DIGIT   = 4'(NDIGITS - 1);
  localparam logic [4:0]    TRIES        = 5'(MAX_TRIES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_OPEN,
    S_PROG,
    S_LOCKOUT
  } state_t;

  state_t        state_q;
  logic [W-1:0]  entry_q;
  logic [W-1:0]  code_q;
  logic [TW-1:0] timer_q;
  logic [3:0]    fail_count_q;
  logic [3:0]    digit_count_q;
  logic          bad_pend_q;
  logic          prog_pend_q;
  logic          unlock_q;
  logic          alarm_q;
  logic          bad_code_q;
  logic          prog_done_q;

  logic [W-1:0] entry_shift;
  logic         last_key;
  logic         lock_on_fail;

  assign entry_shift  = {entry_q[W-5:0], key_digit};
  assign last_key     = (digit_count_q == LAST_DIGIT);
  assign lock_on_fail = ({1'b0, fail_count_q} + 5'd1) >= TRIES;

  // Latch/alarm outputs follow the state with one register stage, so every
  // result appears two edges after the final digit strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      entry_q       <= '0;
      code_q        <= CODE;
      timer_q       <= '0;
      fail_count_q  <= '0;
      digit_count_q <= '0;
      bad_pend_q    <= 1'b0;
      prog_pend_q   <= 1'b0;
      unlock_q      <= 1'b0;
      alarm_q       <= 1'b0;
      bad_code_q    <= 1'b0;
      prog_done_q   <= 1'b0;
    end else begin
      unlock_q    <= (state_q == S_OPEN) || (state_q == S_PROG);
      alarm_q     <= (state_q == S_LOCKOUT);
      bad_code_q  <= bad_pend_q;
      prog_done_q <= prog_pend_q;
      bad_pend_q  <= 1'b0;
      prog_pend_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (key_clear) begin
            entry_q       <= '0;
            digit_count_q <= '0;
          end else if (key_valid) begin
            entry_q       <= entry_shift;
            digit_count_q <= digit_count_q + 4'd1;
            if (last_key) state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          entry_q       <= '0;
          digit_count_q <= '0;
          if (entry_q == code_q) begin
            state_q      <= S_OPEN;
            fail_count_q <= '0;
            timer_q      <= UNLOCK_LOAD;
          end else if (!lock_on_fail) begin
            state_q      <= S_IDLE;
            fail_count_q <= fail_count_q + 4'd1;
            bad_pend_q   <= 1'b1;
          end else begin
            state_q    <= S_LOCKOUT;
            bad_pend_q <= 1'b1;
            timer_q    <= LOCKOUT_LOAD;
          end
        end
        S_OPEN: begin
          if (timer_q != '0) timer_q <= timer_q - 1'b1;
          if (timer_q == '0 || lock_req) state_q <= S_IDLE;
          else if (prog_req)             state_q <= S_PROG;
        end
        S_PROG: begin
          if (key_clear) begin
            entry_q       <= '0;
            digit_count_q <= '0;
            state_q       <= S_IDLE;
          end else if (key_valid) begin
            if (last_key) begin
              code_q        <= entry_shift;
              entry_q       <= '0;
              digit_count_q <= '0;
              prog_pend_q   <= 1'b1;
              state_q       <= S_IDLE;
            end else begin
              entry_q       <= entry_shift;
              digit_count_q <= digit_count_q + 4'd1;
            end
          end
        end
        S_LOCKOUT: begin
          if (timer_q == '0) begin
            state_q      <= S_IDLE;
            fail_count_q <= '0;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign unlock      = unlock_q;
  assign alarm       = alarm_q;
  assign bad_code    = bad_code_q;
  assign prog_done   = prog_done_q;
  assign fail_count  = fail_count_q;
  assign digit_count = digit_count_q;

endmodule

// File: tb/tb_digital_lock_ctrl.sv
// tb/tb_digital_lock_ctrl.sv - scoreboard bench for digital_lock_ctrl
module tb_digital_lock_ctrl;

  localparam int UNLOCK_N  = 8;
  localparam int LOCKOUT_N = 16;
  localparam int TRIES     = 3;
  localparam logic [15:0] RESET_CODE = 16'h1010;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       key_clear = 1'b0;
  logic       lock_req = 1'b0;
  logic       prog_req = 1'b0;
  logic       unlock, alarm, bad_code, prog_done;
  logic [3:0] fail_count, digit_count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         kind;   // 0 open, 1 bad code, 2 lockout
    logic [3:0] fails;
  } exp_t;
  exp_t exp_q[$];

  logic [15:0] model_code = RESET_CODE;
  int          model_fails = 0;

  digital_lock_ctrl #(
    .NDIGITS(4), .CODE(RESET_CODE), .MAX_TRIES(TRIES),
    .UNLOCK_CYCLES(UNLOCK_N), .LOCKOUT_CYCLES(LOCKOUT_N)
  ) dut (
    .clk(clk), .reset_n(reset_n), .key_valid(key_valid), .key_digit(key_digit),
    .key_clear(key_clear), .lock_req(lock_req), .prog_req(prog_req),
    .unlock(unlock), .alarm(alarm), .bad_code(bad_code), .prog_done(prog_done),
    .fail_count(fail_count), .digit_count(digit_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    key_digit = d;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Enters a full code back-to-back and queues the outcome predicted by the model.
  task automatic attempt(input logic [15:0] c);
    exp_t e;
    if (c == model_code) begin
      e.kind = 0; model_fails = 0; e.fails = 4'd0;
    end else if (model_fails + 1 < TRIES) begin
      e.kind = 1; model_fails++; e.fails = 4'(model_fails);
    end else begin
      e.kind = 2; e.fails = 4'(model_fails); model_fails = 0;
    end
    exp_q.push_back(e);
    for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
  endtask

  task automatic wait_result();
    int n = 0;
    int got = -1;
    exp_t e;
    while (got < 0 && n < 10) begin
      tick();
      n++;
      if (alarm === 1'b1)         got = 2;
      else if (unlock === 1'b1)   got = 0;
      else if (bad_code === 1'b1) got = 1;
    end
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL sb_empty got_kind=%0d want=queued_entry", got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e.kind) begin
        failures++;
        $display("FAIL result_kind got=%0d want=%0d", got, e.kind);
      end
      checks++;
      if (n !== 2) begin
        failures++;
        $display("FAIL result_latency got=%0d want=2", n);
      end
      checks++;
      if (fail_count !== e.fails) begin
        failures++;
        $display("FAIL result_fail_count got=%0d want=%0d", fail_count, e.fails);
      end
      if (e.kind == 2) begin
        checks++;
        if (bad_code !== 1'b1) begin
          failures++;
          $display("FAIL lockout_bad_code got=%0b want=1", bad_code);
        end
      end
    end
  endtask

  task automatic measure_unlock();
    int cnt = 0;
    while (unlock === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
    checks++;
    if (cnt !== UNLOCK_N) begin
      failures++;
      $display("FAIL unlock_width got=%0d want=%0d", cnt, UNLOCK_N);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    model_code = RESET_CODE;
    model_fails = 0;
    exp_q.delete();
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #13;
    check("rst_unlock", {31'd0, unlock}, 0);
    check("rst_alarm", {31'd0, alarm}, 0);
    check("rst_bad_code", {31'd0, bad_code}, 0);
    check("rst_prog_done", {31'd0, prog_done}, 0);
    check("rst_fail_count", {28'd0, fail_count}, 0);
    check("rst_digit_count", {28'd0, digit_count}, 0);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_unlock();
    attempt(16'h1010);
    wait_result();
    measure_unlock();
    check("unlock_after_window", {31'd0, unlock}, 0);
    check("unlock_fail_count", {28'd0, fail_count}, 0);
  endtask

  task automatic test_lockout();
    int cnt = 0;
    for (int k = 0; k < 2; k++) begin
      attempt(16'h1111);
      wait_result();
      tick();
      check("bad_code_one_cycle", {31'd0, bad_code}, 0);
    end
    attempt(16'h1111);
    wait_result();
    while (alarm === 1'b1 && cnt < 100) begin
      cnt++;
      key_digit = 4'd1;
      key_valid = (cnt == 3 || cnt == 4);
      tick();
    end
    key_valid = 1'b0;
    check("alarm_width", cnt, LOCKOUT_N);
    check("lockout_keys_ignored", {28'd0, digit_count}, 0);
    check("lockout_fail_cleared", {28'd0, fail_count}, 0);
  endtask

  task automatic test_clear();
    press(4'd1);
    press(4'd0);
    check("partial_digit_count", {28'd0, digit_count}, 2);
    key_clear = 1'b1;
    tick();
    key_clear = 1'b0;
    check("clear_digit_count", {28'd0, digit_count}, 0);
    key_clear = 1'b1;
    press(4'd1);
    key_clear = 1'b0;
    check("clear_beats_valid", {28'd0, digit_count}, 0);
    attempt(16'h1010);
    wait_result();
    measure_unlock();
  endtask

  task automatic test_prog();
    attempt(model_code);
    wait_result();
    prog_req = 1'b1;
    tick();
    prog_req = 1'b0;
    press(4'd2); press(4'd3); press(4'd4); press(4'd5);
    check("prog_unlock_before", {31'd0, unlock}, 1);
    check("prog_done_early", {31'd0, prog_done}, 0);
    tick();
    check("prog_done_pulse", {31'd0, prog_done}, 1);
    check("prog_relocked", {31'd0, unlock}, 0);
    tick();
    check("prog_done_one_cycle", {31'd0, prog_done}, 0);
    model_code = 16'h2345;
    attempt(16'h1010);
    wait_result();
    tick();
    attempt(16'h2345);
    wait_result();
    measure_unlock();
  endtask

  task automatic test_lock_req();
    attempt(model_code);
    wait_result();
    tick();
    lock_req = 1'b1;
    tick();
    lock_req = 1'b0;
    check("lock_req_same_cycle", {31'd0, unlock}, 1);
    tick();
    check("lock_req_drop", {31'd0, unlock}, 0);
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) begin
      attempt(16'h1111);
      wait_result();
    end
    tick(); tick();
    check("pre_reset_alarm", {31'd0, alarm}, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_alarm_drop", {31'd0, alarm}, 0);
    check("async_fail_count", {28'd0, fail_count}, 0);
    do_reset();
    attempt(16'h1010);
    wait_result();
    prog_req = 1'b1;
    tick();
    prog_req = 1'b0;
    press(4'd7); press(4'd7); press(4'd7); press(4'd7);
    model_code = 16'h7777;
    tick(); tick();
    attempt(16'h7777);
    wait_result();
    prog_req = 1'b1;
    tick();
    prog_req = 1'b0;
    press(4'd9);
    press(4'd8);
    check("prog_digits", {28'd0, digit_count}, 2);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_unlock_drop", {31'd0, unlock}, 0);
    check("async_digit_count", {28'd0, digit_count}, 0);
    do_reset();
    attempt(16'h1010);
    wait_result();
    measure_unlock();
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_lockout();
    test_clear();
    test_prog();
    test_lock_req();
    test_async_reset();
    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
